// File: rtl/tff_ctrl_pkg.sv
// Shared state and command encodings for the T-FF counter controller.
// Latency: n/a. Backpressure: n/a.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_STOP = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2,
        OP_CLR  = 2'd3
    } op_t;

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Command channel into the controller: valid/ready plus opcode and terminal count.
// Latency: n/a. Backpressure: cmd_ready low stalls the master.
interface tff_count_ctrl_if #(
    parameter int WIDTH = 4
);
    import tff_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    op_t              cmd_op;
    logic [WIDTH-1:0] limit;

    modport master (output cmd_valid, output cmd_op, output limit, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input limit, output cmd_ready);

endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop with synchronous active-high clear and Q/Qbar outputs.
// Latency: toggles one edge after t is high. Backpressure: none.
module tff_cell (
    input  logic clk,
    input  logic clear,
    input  logic i_t,
    output logic o_q,
    output logic o_q_n
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_q <= 1'b0;
        end else if (i_t) begin
            r_q <= ~r_q;
        end
    end

    assign o_q   = r_q;
    assign o_q_n = ~r_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Drives per-bit toggles of a T-FF bank so it counts up/down modulo a loaded limit.
// Latency: command accept -> one ARM cycle -> first step. Backpressure: cmd_ready low only in ARM.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    tff_count_ctrl_if.slave  cmd,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_n,
    output logic             wrap,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    op_t              r_op_q;
    logic [WIDTH-1:0] r_lim_q;
    logic             r_wrap;
    logic             w_accept;
    logic             w_wrap_apply;
    logic [WIDTH-1:0] w_t_vec;
    logic [WIDTH-1:0] w_up_t;
    logic [WIDTH-1:0] w_dn_t;
    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_count_n;

    assign cmd.cmd_ready = (r_state != ST_ARM);
    assign w_accept      = cmd.cmd_valid & cmd.cmd_ready;

    // Ripple toggle chains: a bit flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        w_up_t    = '0;
        w_dn_t    = '0;
        w_up_t[0] = 1'b1;
        w_dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_up_t[i] = w_up_t[i-1] & w_count[i-1];
            w_dn_t[i] = w_dn_t[i-1] & ~w_count[i-1];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_t_vec      = '0;
        w_wrap_apply = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (r_op_q == OP_CLR) w_t_vec = w_count;
                case (r_op_q)
                    OP_UP:   w_state_nxt = ST_UP;
                    OP_DOWN: w_state_nxt = ST_DOWN;
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
            ST_UP: begin
                if (w_accept) begin
                    w_state_nxt = ST_ARM;
                end else if (w_count >= r_lim_q) begin
                    w_t_vec      = w_count;
                    w_wrap_apply = 1'b1;
                end else begin
                    w_t_vec = w_up_t;
                end
            end
            ST_DOWN: begin
                if (w_accept) begin
                    w_state_nxt = ST_ARM;
                end else if ((w_count == '0) || (w_count > r_lim_q)) begin
                    w_t_vec      = w_count ^ r_lim_q;
                    w_wrap_apply = 1'b1;
                end else begin
                    w_t_vec = w_dn_t;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_op_q  <= OP_STOP;
            r_lim_q <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wrap  <= w_wrap_apply;
            if (w_accept) begin
                r_op_q <= cmd.cmd_op;
                if ((cmd.cmd_op == OP_UP) || (cmd.cmd_op == OP_DOWN)) r_lim_q <= cmd.limit;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .clear (clear),
            .i_t   (w_t_vec[g]),
            .o_q   (w_count[g]),
            .o_q_n (w_count_n[g])
        );
    end

    assign t_vec   = w_t_vec;
    assign count   = w_count;
    assign count_n = w_count_n;
    assign wrap    = r_wrap;
    assign busy    = (r_state == ST_UP) || (r_state == ST_DOWN);

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for a bank of T flip-flops: it owns WIDTH T-FF cells and generates their per-bit toggle enables so the bank behaves as a programmable-modulus up/down counter. Software or a parent FSM issues STOP/UP/DOWN/CLR commands over a valid/ready handshake. The block sits directly above the T-FF cell in the sequential library and is the standard way to run a T-FF bank as a counter.

## Interface
- WIDTH, 4, number of T-FF cells (count width), ≥ 2
- clk  in  1  rising-edge clock, single domain
- clear  in  1  reset, synchronous, active-high; dominates every other input
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  2  0 STOP, 1 UP, 2 DOWN, 3 CLR
- limit  in  WIDTH  terminal count; sampled only when an UP or DOWN command is accepted
- t_vec  out  WIDTH  toggle enables currently driven into the bank
- count  out  WIDTH  Q outputs of the bank
- count_n  out  WIDTH  Qbar outputs of the bank; always ~count
- wrap  out  1  registered one-cycle pulse, high in the cycle after the edge that applied a wrap toggle
- busy  out  1  high in UP or DOWN

## Operation
- States: IDLE, ARM, UP, DOWN. Handshake: accept = cmd_valid & cmd_ready. cmd_ready = 1 in IDLE, UP and DOWN; 0 in ARM.
- Any accepted command moves to ARM for exactly one cycle. Op and limit, the latter for UP/DOWN only, are captured into op_q/lim_q.
- ARM exit: UP → UP; DOWN → DOWN; STOP → IDLE; CLR → IDLE.
- t_vec in ARM: count for CLR, so all set bits toggle to 0; otherwise 0.
- t_vec in IDLE: 0. The bank holds.
- UP: if count ≥ lim_q, t_vec = count (bank → 0) and a wrap is applied. Otherwise t_vec[0] = 1 and t_vec[i] = &count[i-1:0].
- DOWN: if count == 0 or count > lim_q, t_vec = count ^ lim_q (bank → lim_q) and a wrap is applied. Otherwise t_vec[0] = 1 and t_vec[i] = &(~count[i-1:0]).
- lim_q == 0: UP and DOWN both hold 0 and wrap every cycle.
- A command accepted while in UP/DOWN freezes counting. ARM drives t_vec = 0 unless CLR; the new mode starts afterwards with the newly sampled limit.
- clear: all cells Q=0/Qbar=1; state IDLE, op_q=STOP, lim_q=0, wrap=0. cmd_valid in the same cycle is ignored.
- Reset values: count=0, count_n='1, t_vec=0, cmd_ready=1, wrap=0, busy=0.

## Timing
- Command accepted at edge E0. ARM is the cycle after E0.
- CLR: count = 0 after E1; IDLE after E1.
- UP/DOWN: state after E1; first count change at E2. After that, one step per edge.
- STOP: count frozen from E0 onward; IDLE after E1.
- wrap is high for the single cycle following the edge at which count took its wrap value (0 for UP, lim_q for DOWN).
- clear mid-operation takes effect at the next edge regardless of state, including ARM.

## Structure
- Package tff_ctrl_pkg holds state_t (IDLE, ARM, UP, DOWN) and op_t (STOP=0, UP=1, DOWN=2, CLR=3).
- Sub-module tff_cell: one T flip-flop with synchronous active-high clear and Q/Qbar outputs, instantiated WIDTH times. Q resets to 0 and Qbar to 1; each toggles when t is high.
- All t_vec logic is combinational from state, count and lim_q. Only the cells, state, op_q, lim_q and wrap are registered.

## Test plan (WIDTH=4)
- Reset: clear=1 for 2 cycles with cmd_valid=1, cmd_op=UP → count=0, count_n=4'hF, cmd_ready=1, busy=0, wrap=0; no ARM entry.
- UP limit=5 from 0: accept at E0; cmd_ready=0 for one cycle; count 1 after E2; sequence 1,2,3,4,5,0. wrap high for the one cycle after count becomes 0.
- STOP mid-count: STOP accepted while count=3 → count holds 3 indefinitely; busy=0 after E1.
- DOWN limit=9 from count=3: sequence 2,1,0,9 with wrap pulse after 9. Then CLR accepted at count=6 → count=0 one edge after accept, state IDLE, count_n=4'hF.
- Limit shrink: DOWN limit=7 from 0 (count → 7, wrap), then UP limit=3 → first step 7→0 with wrap, then 1,2,3,0. UP limit=0 → count stays 0 with wrap high every cycle.
- clear during UP at count=4 with cmd_valid=1, cmd_op=CLR → count=0 next edge, IDLE, wrap=0, command not accepted; counting resumes only after a new UP.
